// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-128 round sequencer and key-schedule datapath.
// Holds the sequencer state encoding, the nominal round count, the round-index width
// and the round-constant table (entry 0 is the constant for round 1).
package aes_pkg;

  localparam int NR_AES128 = 10;
  localparam int IDX_W     = 4;

  localparam logic [NR_AES128-1:0][7:0] RCON_TAB = {
    8'h36, 8'h1b, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01
  };

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_EXPAND = 3'd2,
    ST_INIT   = 3'd3,
    ST_ROUND  = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

endpackage

// File: rtl/aes_rcon_gen.sv
// Round-constant lookup: maps round_idx to its AES round constant.
// Purely combinational, zero latency; no flow control.
// Index 0 and indices above 10 give 0x00.
module aes_rcon_gen
  import aes_pkg::*;
(
  input  logic [IDX_W-1:0] round_idx,
  output logic [7:0]       rcon
);

  // Table lookup, guarded so out-of-range indices read as zero.
  always_comb begin
    rcon = 8'h00;
    if (round_idx >= IDX_W'(1) && round_idx <= IDX_W'(NR_AES128)) begin
      rcon = RCON_TAB[round_idx - IDX_W'(1)];
    end
  end

endmodule

// File: rtl/aes_round_ctrl.sv
// Round sequencer for the AES-128 core: load, optional forward key expansion, NR rounds, done pulse.
// Encrypt takes NR+2 cycles after start, decrypt 2*NR+3; outputs are Moore-decoded from state and counter.
// start is ignored while busy; abort returns to IDLE at the next edge. AES_DECRYPT_EN builds the decrypt path.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR = NR_AES128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             mode,
  output logic             busy,
  output logic             key_load,
  output logic             state_load,
  output logic             round_en,
  output logic             last_round,
  output logic             key_step,
  output logic             key_dir,
  output logic [IDX_W-1:0] round_idx,
  output logic [7:0]       rcon,
  output logic             done
);

  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NR);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             mode_q;

`ifdef AES_DECRYPT_EN
  // Latch the direction only when a start is actually accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q <= 1'b0;
    end else if (state_q == ST_IDLE && start && !abort) begin
      mode_q <= mode;
    end
  end
`else
  // Encrypt-only build: direction is fixed and the mode input has no effect.
  logic unused_mode;
  assign unused_mode = mode;
  assign mode_q      = 1'b0;
`endif

  // State register and round counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, counter update and Moore output decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    key_load   = 1'b0;
    state_load = 1'b0;
    round_en   = 1'b0;
    last_round = 1'b0;
    key_step   = 1'b0;
    key_dir    = 1'b0;
    round_idx  = '0;
    done       = 1'b0;
    busy       = (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        key_load = 1'b1;
        cnt_d    = IDX_ONE;
        if (mode_q) begin
          state_d = ST_EXPAND;
        end else begin
          state_load = 1'b1;
          state_d    = ST_ROUND;
        end
      end
`ifdef AES_DECRYPT_EN
      ST_EXPAND: begin
        // Run the key schedule forward to the last round key before decrypting.
        key_step  = 1'b1;
        round_idx = cnt_q;
        if (cnt_q == IDX_LAST) state_d = ST_INIT;
        else                   cnt_d   = cnt_q + IDX_ONE;
      end
      ST_INIT: begin
        state_load = 1'b1;
        cnt_d      = IDX_LAST;
        state_d    = ST_ROUND;
      end
`endif
      ST_ROUND: begin
        round_en  = 1'b1;
        key_step  = 1'b1;
        round_idx = cnt_q;
        if (mode_q) begin
          // Decrypt walks the rounds backwards with inverse key steps.
          key_dir    = 1'b1;
          last_round = (cnt_q == IDX_ONE);
          cnt_d      = cnt_q - IDX_ONE;
        end else begin
          last_round = (cnt_q == IDX_LAST);
          cnt_d      = cnt_q + IDX_ONE;
        end
        if (last_round) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (abort) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end
  end

  aes_rcon_gen u_rcon (
    .round_idx (round_idx),
    .rcon      (rcon)
  );

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: two instances (NR=10 and NR=3) share the same stimulus.
// A timeline model (cycle offset since the accepted start) predicts every output each cycle.
// Directed scenarios pin exact cycle numbers; a random phase exercises start/abort/mode/reset.
module tb_aes_round_ctrl;

`ifdef AES_DECRYPT_EN
  localparam bit DEC_EN = 1'b1;
`else
  localparam bit DEC_EN = 1'b0;
`endif

  localparam int NN [2] = '{10, 3};
  localparam logic [7:0] RC [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                     8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  typedef struct packed {
    logic       busy;
    logic       key_load;
    logic       state_load;
    logic       round_en;
    logic       last_round;
    logic       key_step;
    logic       key_dir;
    logic       done;
    logic [3:0] idx;
    logic [7:0] rcon;
  } outs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic mode = 1'b0;

  logic [1:0] busy_w, kl_w, sl_w, re_w, lr_w, ks_w, kd_w, dn_w;
  logic [3:0] idx_w [2];
  logic [7:0] rc_w [2];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  aes_round_ctrl #(.NR(10)) u_dut10 (
    .clk(clk), .reset(rst_n), .start(start), .abort(abort), .mode(mode),
    .busy(busy_w[0]), .key_load(kl_w[0]), .state_load(sl_w[0]), .round_en(re_w[0]),
    .last_round(lr_w[0]), .key_step(ks_w[0]), .key_dir(kd_w[0]),
    .round_idx(idx_w[0]), .rcon(rc_w[0]), .done(dn_w[0])
  );

  aes_round_ctrl #(.NR(3)) u_dut3 (
    .clk(clk), .reset(rst_n), .start(start), .abort(abort), .mode(mode),
    .busy(busy_w[1]), .key_load(kl_w[1]), .state_load(sl_w[1]), .round_en(re_w[1]),
    .last_round(lr_w[1]), .key_step(ks_w[1]), .key_dir(kd_w[1]),
    .round_idx(idx_w[1]), .rcon(rc_w[1]), .done(dn_w[1])
  );

  function automatic outs_t got(int i);
    outs_t o;
    o = {busy_w[i], kl_w[i], sl_w[i], re_w[i], lr_w[i], ks_w[i], kd_w[i], dn_w[i],
         idx_w[i], rc_w[i]};
    return o;
  endfunction

  // Expected outputs k cycles after an accepted start (k=1 is the load cycle).
  function automatic outs_t model_out(bit act, int k, bit dec, int n);
    outs_t o;
    int r;
    o = '0;
    if (act) begin
      o.busy = 1'b1;
      if (k == 1) begin
        o.key_load   = 1'b1;
        o.state_load = !dec;
      end else if (!dec) begin
        if (k <= n + 1) begin
          r = k - 1;
          o.round_en = 1'b1; o.key_step = 1'b1; o.idx = 4'(r); o.last_round = (r == n);
        end else begin
          o.done = 1'b1;
        end
      end else begin
        if (k <= n + 1) begin
          o.key_step = 1'b1; o.idx = 4'(k - 1);
        end else if (k == n + 2) begin
          o.state_load = 1'b1;
        end else if (k <= 2 * n + 2) begin
          r = 2 * n + 3 - k;
          o.round_en = 1'b1; o.key_step = 1'b1; o.key_dir = 1'b1;
          o.idx = 4'(r); o.last_round = (r == 1);
        end else begin
          o.done = 1'b1;
        end
      end
      if (o.idx != 0) o.rcon = RC[o.idx - 1];
    end
    return o;
  endfunction

  bit m_act [2];
  int m_k   [2];
  bit m_dec [2];

  // Reference timeline: an operation lasts n+2 (encrypt) or 2n+3 (decrypt) cycles.
  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_act[i] <= 1'b0;
        m_k[i]   <= 0;
      end else if (abort) begin
        m_act[i] <= 1'b0;
      end else if (!m_act[i]) begin
        if (start) begin
          m_act[i] <= 1'b1;
          m_k[i]   <= 1;
          m_dec[i] <= DEC_EN & mode;
        end
      end else if (m_k[i] >= (m_dec[i] ? 2 * NN[i] + 3 : NN[i] + 2)) begin
        m_act[i] <= 1'b0;
      end else begin
        m_k[i] <= m_k[i] + 1;
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      outs_t e, g;
      e = model_out(m_act[i], m_k[i], m_dec[i], NN[i]);
      g = got(i);
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL cycle_cmp nr=%0d t=%0t got=%h want=%h", NN[i], $time, g, e);
      end
    end
  end

  task automatic chk(input string name, input int g, input int e);
    total++;
    if (g != e) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, g, e);
    end
  endtask

  outs_t rec [2][64];

  // Drives start at cycle 0 and the listed cycles, optional abort/reset; records outputs per cycle.
  task automatic go(input int ncyc, input bit md, input int s1, input int s2, input int s3,
                    input int ab, input int rs);
    for (int c = 0; c <= ncyc; c++) begin
      @(negedge clk);
      rec[0][c] = got(0);
      rec[1][c] = got(1);
      mode  = md;
      start = (c == 0 || c == s1 || c == s2 || c == s3);
      abort = (c == ab);
      if (c == rs) begin
        rst_n = 1'b0;
        #1;
        chk("reset_async_outputs_zero", int'(got(0)), 0);
      end
      if (c == rs + 2) rst_n = 1'b1;
    end
    start = 1'b0;
    abort = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  function automatic int first_done(int i, int n);
    for (int c = 0; c <= n; c++) if (rec[i][c].done) return c;
    return -1;
  endfunction

  function automatic int count_done(int i, int n);
    int cnt = 0;
    for (int c = 0; c <= n; c++) if (rec[i][c].done) cnt++;
    return cnt;
  endfunction

  initial begin
    int lr_cnt;
    // Model pins against hand-derived values.
    chk("model_enc_k11_rcon", int'(model_out(1'b1, 11, 1'b0, 10).rcon), 8'h36);
    chk("model_enc_k12_done", int'(model_out(1'b1, 12, 1'b0, 10).done), 1);
    chk("model_dec_k12_sload", int'(model_out(1'b1, 12, 1'b1, 10).state_load), 1);
    chk("model_dec_k22_idx", int'(model_out(1'b1, 22, 1'b1, 10).idx), 1);

    repeat (3) @(negedge clk);
    chk("reset_outputs", int'(got(0)), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_after_reset", int'(busy_w), 0);

    // Encrypt, both NR values.
    go(14, 1'b0, -1, -1, -1, -1, -1);
    chk("enc_load_keyload", int'(rec[0][1].key_load), 1);
    chk("enc_load_stateload", int'(rec[0][1].state_load), 1);
    for (int c = 2; c <= 11; c++) chk("enc_rcon_seq", int'(rec[0][c].rcon), int'(RC[c - 2]));
    lr_cnt = 0;
    for (int c = 0; c <= 14; c++) if (rec[0][c].last_round) lr_cnt++;
    chk("enc_last_round_count", lr_cnt, 1);
    chk("enc_last_round_c11", int'(rec[0][11].last_round), 1);
    chk("enc_done_cycle", first_done(0, 14), 12);
    chk("enc_done_count", count_done(0, 14), 1);
    chk("nr3_done_cycle", first_done(1, 14), 5);
    chk("nr3_rcon_c4", int'(rec[1][4].rcon), 8'h04);
    chk("nr3_last_c4", int'(rec[1][4].last_round), 1);

    // Decrypt (only meaningful when the decrypt path is built).
    go(25, 1'b1, -1, -1, -1, -1, -1);
    if (DEC_EN) begin
      chk("dec_done_cycle", first_done(0, 25), 23);
      chk("dec_expand_idx2", int'(rec[0][2].idx), 1);
      chk("dec_init_c12", int'(rec[0][12].state_load), 1);
      chk("dec_round_c13_idx", int'(rec[0][13].idx), 10);
      chk("dec_keydir_c22", int'(rec[0][22].key_dir), 1);
      chk("dec_nr3_done", first_done(1, 25), 9);
    end else begin
      chk("enconly_done_cycle", first_done(0, 25), 12);
      chk("enconly_keydir", int'(rec[0][11].key_dir), 0);
    end

    // start during ROUND and DONE ignored; back-to-back start in the cycle after DONE.
    go(27, 1'b0, 6, 12, 13, -1, -1);
    chk("b2b_first_done", first_done(0, 27), 12);
    chk("b2b_done_count", count_done(0, 27), 2);
    chk("b2b_second_done", int'(rec[0][25].done), 1);

    // abort at ROUND idx 4.
    go(16, 1'b0, -1, -1, -1, 5, -1);
    chk("abort_idx_still_driven", int'(rec[0][5].idx), 4);
    chk("abort_busy_next", int'(rec[0][6].busy), 0);
    chk("abort_no_done", count_done(0, 16), 0);

    // abort and start together in IDLE.
    go(4, 1'b0, -1, -1, -1, 0, -1);
    chk("abort_start_idle", int'(rec[0][1].busy), 0);

    // Reset mid-ROUND at idx 5, then a fresh encrypt.
    go(10, 1'b0, -1, -1, -1, -1, 6);
    chk("rst_pre_idx", int'(rec[0][6].idx), 5);
    chk("rst_busy_low", int'(rec[0][7].busy), 0);
    go(14, 1'b0, -1, -1, -1, -1, -1);
    chk("post_rst_done", first_done(0, 14), 12);

    // Random phase.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      abort = ($urandom_range(0, 39) == 0);
      mode  = 1'($urandom_range(0, 1));
      rst_n = ($urandom_range(0, 499) != 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

Round sequencer for the AES-128 core. It sits between the host-interface FSM and the round datapath (state register, round function, key-schedule register). On `start` it loads message and key, steps the datapath through NR rounds with the correct round constant, and pulses `done` so the interface loads the ciphertext into its 128-to-32 output shift register.

## Interface
Parameters:
- NR, 10, number of rounds; legal range 1..10 (values below 10 are a reduced-round debug mode)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; all state cleared while low
- start  in  1  single-cycle request from the interface FSM; message and key are already valid
- abort  in  1  synchronous cancel; returns to IDLE with no `done`
- mode  in  1  0 = encrypt, 1 = decrypt; sampled with `start` (see Configuration)
- busy  out  1  high in every state except IDLE
- key_load  out  1  key-schedule register captures `key`
- state_load  out  1  state register captures message XOR current round key
- round_en  out  1  state register captures round-function output
- last_round  out  1  round function bypasses (Inv)MixColumns
- key_step  out  1  key-schedule register advances one round
- key_dir  out  1  0 = forward key step, 1 = inverse key step
- round_idx  out  4  current round number, 0 outside rounds
- rcon  out  8  round constant for round_idx, 0x00 when round_idx = 0
- done  out  1  one-cycle pulse, ciphertext/plaintext valid on the datapath

## Operation
- Moore FSM. All outputs are decoded from the state register and the round counter.
- Reset value of every output is 0. State resets to IDLE, counter to 0, and the mode register to 0.
- States: IDLE, LOAD, EXPAND, INIT, ROUND, DONE.
- IDLE: `start` moves to LOAD and latches `mode`. `start` in any other state is ignored.
- LOAD: `key_load` = 1. In encrypt, `state_load` = 1 also, then go to ROUND with idx = 1. In decrypt, go to EXPAND with idx = 1.
- EXPAND (decrypt only): `key_step` = 1, `key_dir` = 0, idx counts 1..NR. After idx = NR, go to INIT.
- INIT (decrypt only): `state_load` = 1, which XORs with round key NR. Go to ROUND with idx = NR.
- ROUND, encrypt: `round_en` = `key_step` = 1, idx counts 1..NR, `last_round` = 1 at idx = NR.
- ROUND, decrypt: `key_dir` = 1, idx counts NR..1, `last_round` = 1 at idx = 1.
- After the final round, go to DONE. DONE asserts `done` for one cycle, then returns to IDLE.
- `rcon` is looked up from `round_idx` (01,02,04,08,10,20,40,80,1B,36 for 1..10).
- `abort` is honoured in any state: next state is IDLE, idx = 0, and no `done` is issued.
- `abort` and `start` together in IDLE: `abort` wins and the block stays IDLE.
- Reset mid-operation: immediate return to IDLE with all outputs 0. The datapath contents are don't-care.

## Timing
- Encrypt (start sampled in cycle 0): LOAD in cycle 1, ROUND in cycles 2..NR+1, DONE in cycle NR+2. That is 12 cycles at NR = 10.
- Decrypt: LOAD in cycle 1, EXPAND in cycles 2..NR+1, INIT in cycle NR+2, ROUND in cycles NR+3..2NR+2, DONE in cycle 2NR+3. That is 23 cycles at NR = 10.
- Earliest next `start` is accepted in the cycle after DONE (IDLE), giving a throughput of one block per NR+3 cycles in encrypt.
- `abort` takes effect at the next clock edge; the outputs of the aborted cycle are still driven.

## Configuration
- AES_DECRYPT_EN defined: the `mode` port is functional, and the EXPAND and INIT states and inverse stepping are built.
- AES_DECRYPT_EN undefined: `mode` is ignored and the block always encrypts. EXPAND/INIT are not generated, and `key_dir` is tied to 0.
- The port list is identical in both builds.

## Structure
- Shared package aes_pkg holds: the state enum type, localparam NR_AES128 = 10, the 10-entry RCON table, and the round-index width.
- One sub-module, aes_rcon_gen: combinational `round_idx` to `rcon` lookup (0x00 for idx 0 or idx > 10). It is reused by the key-schedule datapath.
- The controller holds the FSM, the round counter and the latched mode bit.

## Test plan
- Reset low mid-ROUND at idx 5 -> all outputs 0 immediately and IDLE after release; next `start` -> `done` at cycle 12.
- Encrypt, NR = 10, `start` pulse -> LOAD at cycle 1 with `key_load` = `state_load` = 1; `rcon` sequence 01..36 over cycles 2..11; `last_round` only at cycle 11; `done` at cycle 12. The FIPS-197 vector (key 000102..0f, pt 00112233..ff) gives ct 69c4e0d8..c55a with the datapath model.
- Decrypt (AES_DECRYPT_EN) -> EXPAND idx 1..10, INIT at cycle 12, ROUND idx 10..1 with `key_dir` = 1, `done` at cycle 23; the FIPS vector round-trips.
- `start` asserted during ROUND and during DONE -> ignored, exactly one `done`; back-to-back `start` at cycle 13 -> second `done` at cycle 25.
- `abort` at ROUND idx 4 -> IDLE next cycle, no `done`. `abort` + `start` together in IDLE -> stays IDLE, `busy` stays 0.
- NR = 3, encrypt -> rounds 1..3 with `rcon` 01,02,04, `last_round` at idx 3, `done` at cycle 5.
